sumsq_sqrt_frame: RTL
=====================

Name: sumsq_sqrt_frame

Overview:
- Parametrised successor to the streaming sum-of-squares/square-root datapath.
- Accumulates the squares of input samples over a frame that the producer delimits with `last_in`.
- At frame end, computes floor(sqrt(sum)) with an iterative one-bit-per-cycle root engine instead of a combinational root.
- Adds valid/ready handshakes on both sides, a saturating accumulator with a sticky overflow flag, and optional signed input.
- Sits between the sample source and the downstream magnitude consumer.

Parameters:
- DATA_W, 8: input sample width; legal range 2..16.
- ACC_W, 20: accumulator width; must be even and >= 2*DATA_W. The root is ACC_W/2 bits wide.
- SIGNED, 0: 0 = `a` is unsigned; 1 = `a` is two's complement and is squared as signed.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- a, input, DATA_W: sample.
- valid_in, input, 1: `a` and `last_in` are valid.
- last_in, input, 1: this sample closes the frame; qualified by valid_in.
- ready_in, output, 1: block accepts a sample this cycle.
- g, output, ACC_W/2: floor(sqrt(saturated frame sum)).
- overflow, output, 1: the frame sum saturated.
- valid_out, output, 1: `g` and `overflow` are valid.
- ready_out, input, 1: consumer accepts the result.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed): state=ACCUM, acc=0, overflow=0, g=0, valid_out=0, sqrt registers=0. Reset asserted mid-frame or mid-SQRT discards all work. First sample is accepted on the first edge after deassertion.
- FSM states: ACCUM, SQRT, HOLD.
  - ready_in = (state==ACCUM). This is combinational from state only.
  - valid_out = (state==HOLD). It is registered.
- ACCUM:
  - Beat accepted when valid_in && ready_in.
  - sq = a*a is computed in 2*DATA_W bits (signed product if SIGNED=1; the result is always non-negative).
  - sum = acc + sq computed in ACC_W+1 bits. If bit ACC_W is set, acc = 2^ACC_W-1 and overflow=1 (sticky for the frame); otherwise acc = sum.
  - valid_in=0 cycles leave all state unchanged. Gaps between beats of any length are allowed.
  - An accepted beat with last_in=1 latches the updated (saturated) acc as the radicand and moves to SQRT with bit counter = ACC_W/2-1. A single-beat frame is legal.
  - last_in without valid_in is ignored.
- SQRT: digit-by-digit restoring root, one result bit per edge, MSB first.
  - Each edge: bring the next 2 radicand bits into the remainder, trial = remainder - (root<<2 | 1). If the trial is non-negative, keep it and shift 1 into root; else shift 0.
  - The edge with counter==0 writes the root to `g` and moves to HOLD.
  - Latency: last beat accepted on edge k means valid_out=1 after edge k+ACC_W/2 (edge k+10 at default parameters).
  - acc is cleared on entry to SQRT; samples are not accepted (ready_in=0).
- HOLD:
  - g and overflow are stable while valid_out=1 and ready_out=0, for as many cycles as needed.
  - On valid_out && ready_out: go to ACCUM; overflow clears; valid_out falls. The next sample can be accepted on the following edge.
- Outside HOLD, `g` holds the last result (0 after reset). `overflow` reflects the in-progress frame.
- Arithmetic: all widths zero-extend, except the signed product when SIGNED=1. No rounding: the result is floor. Maximum result is 2^(ACC_W/2)-1.

Test Plan:
1. Defaults; frame 21, 36 (last), ready_out=1 -> valid_out high for 1 cycle exactly 10 cycles after the last beat edge; g=41 (sum 1737); overflow=0.
2. Frame 21, idle, idle, 36, idle, 64 (last) -> idle cycles ignored; g=76 (sum 5833); then frame 3, 4 (last) -> g=5, proving acc cleared between frames.
3. Back-pressure: result ready, ready_out=0 for 6 cycles, valid_in=1 with a=99 throughout -> valid_out and g=41 stable; ready_in=0; no sample absorbed; the next frame 3, 4 gives g=5.
4. Saturation: 17 beats of a=255, the 17th with last -> overflow=1, g=1023; next frame 1 (last) -> g=1, overflow=0.
5. SIGNED=1, DATA_W=8: a=0xFB (-5), a=12 (last) -> g=13 (sum 169); a=0x80 (last) -> g=128.
6. Async reset: reset=0 between edges, 4 cycles into SQRT -> valid_out, g, overflow are 0 before the next edge and ready_in=1 after deassertion. Frame 0 (last, single beat) then gives g=0 with valid_out=1 after 10 cycles.

Source files
------------

// File: rtl/sumsq_sqrt_frame_if.sv
// Sample-in / result-out bus for the frame sum-of-squares root block.
//
// Handshake semantics (both directions): a transfer happens on a rising clk
// edge where the sender's valid and the receiver's ready are both 1. A sender
// may raise valid at any time. While valid is 1 and no transfer has happened,
// the sender keeps its payload unchanged. ready is allowed to depend on state
// only; it never depends combinationally on the matching valid.
//   sample side : valid_in / ready_in carry {a, last_in}
//   result side : valid_out / ready_out carry {g, overflow}
interface sumsq_sqrt_frame_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic [DATA_W-1:0]  a;
    logic               valid_in;
    logic               last_in;
    logic               ready_in;
    logic [ACC_W/2-1:0] g;
    logic               overflow;
    logic               valid_out;
    logic               ready_out;

    // Block side
    modport slave (
        input  a, valid_in, last_in, ready_out,
        output ready_in, g, overflow, valid_out
    );

    // Producer/consumer side
    modport master (
        output a, valid_in, last_in, ready_out,
        input  ready_in, g, overflow, valid_out
    );
endinterface

// File: rtl/sumsq_sqrt_frame.sv
// Frame sum-of-squares with an iterative floor-square-root.
// Samples are squared and summed into a saturating accumulator. When the
// frame-closing beat arrives, the sum becomes the radicand of a restoring
// root engine that produces one result bit per clock, MSB first. The result
// is then held until the consumer takes it.
// DATA_W must be in 2..16; ACC_W must be even and at least 2*DATA_W.
module sumsq_sqrt_frame #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    sumsq_sqrt_frame_if.slave    bus,
    output logic [1:0]           state_dbg
);
    localparam int HW    = ACC_W / 2;
    localparam int CNT_W = (HW > 2) ? $clog2(HW) : 1;
    localparam int REM_W = HW + 2;
    localparam int TRY_W = REM_W + 2;
    localparam int SQ_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SQRT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               valid_out_q;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W-1:0]   rad;
    logic [REM_W-1:0]   rem;
    logic [HW-1:0]      root;
    logic [CNT_W-1:0]   cnt;
    logic [HW-1:0]      g_q;

    logic               beat;
    logic [SQ_W-1:0]    sq;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_upd;
    logic               ovf_upd;
    logic [TRY_W-1:0]   rem_sh;
    logic [TRY_W-1:0]   sub;
    logic               take;
    logic [REM_W-1:0]   rem_nxt;
    logic [HW-1:0]      root_nxt;

    // Square of the sample; the signed square of a two's complement value is
    // never negative and fits 2*DATA_W bits even for the most negative input.
    generate
        if (SIGNED) begin : g_sq_signed
            logic signed [SQ_W-1:0] a_sx;
            logic signed [SQ_W-1:0] sq_s;
            assign a_sx = SQ_W'($signed(bus.a));
            assign sq_s = a_sx * a_sx;
            assign sq   = sq_s;
        end else begin : g_sq_unsigned
            logic [SQ_W-1:0] a_zx;
            assign a_zx = SQ_W'(bus.a);
            assign sq   = a_zx * a_zx;
        end
    endgenerate

    // Accumulate with one guard bit; a carry into it pins the sum at full scale.
    always_comb begin
        beat    = bus.valid_in && (state == ACCUM);
        sum_ext = {1'b0, acc} + (ACC_W+1)'(sq);
        acc_upd = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        ovf_upd = ovf | sum_ext[ACC_W];
    end

    // One restoring-root step: pull two radicand bits, try subtracting 4r+1.
    always_comb begin
        rem_sh   = {rem, rad[ACC_W-1 -: 2]};
        sub      = TRY_W'({root, 2'b01});
        take     = (rem_sh >= sub);
        rem_nxt  = take ? REM_W'(rem_sh - sub) : REM_W'(rem_sh);
        root_nxt = {root[HW-2:0], take};
    end

    // Next-state decode for ACCUM -> SQRT -> HOLD -> ACCUM.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (beat && bus.last_in) state_nxt = SQRT;
            SQRT:    if (cnt == '0) state_nxt = HOLD;
            HOLD:    if (bus.ready_out) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // State register and the registered result-valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ACCUM;
            valid_out_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            valid_out_q <= (state_nxt == HOLD);
        end
    end

    // Accumulator, overflow flag, root engine and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            ovf  <= 1'b0;
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            g_q  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        ovf <= ovf_upd;
                        if (bus.last_in) begin
                            rad  <= acc_upd;
                            acc  <= '0;
                            rem  <= '0;
                            root <= '0;
                            cnt  <= CNT_W'(HW - 1);
                        end else begin
                            acc <= acc_upd;
                        end
                    end
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) g_q <= root_nxt;
                end
                HOLD: begin
                    if (bus.ready_out) ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_in  = (state == ACCUM);
    assign bus.valid_out = valid_out_q;
    assign bus.g         = g_q;
    assign bus.overflow  = ovf;
    assign state_dbg     = state;

endmodule
